// File: rtl/conv_cnt_pkg.sv
// Shared FSM encoding and default widths for the convolution index counter.
package conv_cnt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_COL_W = 5;
  localparam int DEF_ROW_W = 5;
  localparam int DEF_CH_W  = 8;

endpackage

// File: rtl/conv_index_counter_wrap_counter.sv
// One scan dimension: latches its max and increment on load, steps and wraps to 0.
module wrap_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clr,
  input  logic         step,
  input  logic [W-1:0] max_in,
  input  logic [W-1:0] incr_in,
  output logic [W-1:0] value,
  output logic         wrap
);

  logic [W-1:0] value_q, value_d;
  logic [W-1:0] max_q, max_d;
  logic [W-1:0] incr_q, incr_d;
  logic [W:0]   next_sum;

  // Extra bit so value + incr cannot overflow before the compare against max.
  assign next_sum = {1'b0, value_q} + {1'b0, incr_q};
  assign wrap     = next_sum > {1'b0, max_q};
  assign value    = value_q;

  always_comb begin
    value_d = value_q;
    max_d   = max_q;
    incr_d  = incr_q;
    if (clr) begin
      value_d = '0;
    end else if (load) begin
      value_d = '0;
      max_d   = max_in;
      incr_d  = (incr_in == '0) ? W'(1) : incr_in;
    end else if (step) begin
      value_d = wrap ? '0 : next_sum[W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
      max_q   <= '0;
      incr_q  <= W'(1);
    end else begin
      value_q <= value_d;
      max_q   <= max_d;
      incr_q  <= incr_d;
    end
  end

endmodule

// File: rtl/conv_index_counter.sv
// Nested col/row/ch scan counter with IDLE/RUN/DONE control.
// Define CONV_CNT_STRIDE_EN to add a programmable column stride (col_stride).
module conv_index_counter
  import conv_cnt_pkg::*;
#(
  parameter int COL_W = DEF_COL_W,
  parameter int ROW_W = DEF_ROW_W,
  parameter int CH_W  = DEF_CH_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             enable,
  input  logic             clear,
`ifdef CONV_CNT_STRIDE_EN
  input  logic [COL_W-1:0] col_stride,
`endif
  input  logic [COL_W-1:0] col_max,
  input  logic [ROW_W-1:0] row_max,
  input  logic [CH_W-1:0]  ch_max,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic [CH_W-1:0]  ch,
  output logic             col_wrap,
  output logic             row_wrap,
  output logic             busy,
  output logic             done,
  output logic             last,
  output logic [1:0]       state_dbg
);

  state_e state_q, state_d;
  logic   load, step;
  logic   col_end, row_end, ch_end;
  logic [COL_W-1:0] col_incr;

`ifdef CONV_CNT_STRIDE_EN
  assign col_incr = col_stride;
`else
  assign col_incr = COL_W'(1);
`endif

  // Handshake: start is taken only in IDLE, enable only in RUN; clear overrides both.
  assign load = (state_q == ST_IDLE) && start && !clear;
  assign step = (state_q == ST_RUN) && enable && !clear;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (enable && last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (clear) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  wrap_counter #(.W(COL_W)) u_col (
    .clk(clk), .reset(reset), .load(load), .clr(clear), .step(step),
    .max_in(col_max), .incr_in(col_incr), .value(col), .wrap(col_end)
  );

  wrap_counter #(.W(ROW_W)) u_row (
    .clk(clk), .reset(reset), .load(load), .clr(clear), .step(step && col_end),
    .max_in(row_max), .incr_in(ROW_W'(1)), .value(row), .wrap(row_end)
  );

  wrap_counter #(.W(CH_W)) u_ch (
    .clk(clk), .reset(reset), .load(load), .clr(clear),
    .step(step && col_end && row_end),
    .max_in(ch_max), .incr_in(CH_W'(1)), .value(ch), .wrap(ch_end)
  );

  // All flags decode registered state only; the col flag marks the position that wraps next.
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign col_wrap  = busy && col_end;
  assign row_wrap  = busy && row_end;
  assign last      = busy && col_end && row_end && ch_end;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_conv_index_counter.sv
// Directed self-checking bench for conv_index_counter (stride case under CONV_CNT_STRIDE_EN).
module tb_conv_index_counter;
  import conv_cnt_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       enable = 1'b0;
  logic       clear = 1'b0;
  logic [4:0] col_stride = 5'd0;
  logic [4:0] col_max = 5'd0;
  logic [4:0] row_max = 5'd0;
  logic [7:0] ch_max = 8'd0;
  logic [4:0] col;
  logic [4:0] row;
  logic [7:0] ch;
  logic       col_wrap, row_wrap, busy, done, last;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [17:0] exp_q[$];

  conv_index_counter dut (
    .clk(clk), .reset(reset), .start(start), .enable(enable), .clear(clear),
`ifdef CONV_CNT_STRIDE_EN
    .col_stride(col_stride),
`endif
    .col_max(col_max), .row_max(row_max), .ch_max(ch_max),
    .col(col), .row(row), .ch(ch), .col_wrap(col_wrap), .row_wrap(row_wrap),
    .busy(busy), .done(done), .last(last), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] triple(input logic [7:0] c, input logic [4:0] r, input logic [4:0] k);
    return {c, r, k};
  endfunction

  task automatic do_start(input logic [4:0] cm, input logic [4:0] rm, input logic [7:0] hm);
    col_max = cm; row_max = rm; ch_max = hm;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_idx"}, 32'(triple(ch, row, col)), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_last"}, 32'(last), 32'd0);
    check_eq({tag, "_state"}, 32'(state_dbg), 32'(ST_IDLE));
  endtask

  // 3x2x2 scan; stall inserts an idle-enable cycle before every step.
  task automatic scan(input bit stall);
    logic [17:0] e;
    string tg;
    exp_q.delete();
    for (int h = 0; h < 2; h++)
      for (int r = 0; r < 2; r++)
        for (int k = 0; k < 3; k++)
          exp_q.push_back(triple(8'(h), 5'(r), 5'(k)));
    tg = stall ? "stall" : "scan";
    do_start(5'd2, 5'd1, 8'd1);
    if (stall) begin
      col_max = 5'd0; row_max = 5'd0; ch_max = 8'd0;
    end
    check_eq({tg, "_busy"}, 32'(busy), 32'd1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (stall) begin
        enable = 1'b0;
        tick();
        check_eq({tg, "_hold"}, 32'(triple(ch, row, col)), 32'(e));
      end
      enable = 1'b1;
      check_eq({tg, "_idx"}, 32'(triple(ch, row, col)), 32'(e));
      check_eq({tg, "_colwrap"}, 32'(col_wrap), 32'(e[4:0] == 5'd2));
      check_eq({tg, "_rowwrap"}, 32'(row_wrap), 32'(e[9:5] == 5'd1));
      check_eq({tg, "_last"}, 32'(last), 32'(exp_q.size() == 0));
      check_eq({tg, "_done_low"}, 32'(done), 32'd0);
      tick();
      enable = 1'b0;
    end
    check_eq({tg, "_done"}, 32'(done), 32'd1);
    check_eq({tg, "_done_busy"}, 32'(busy), 32'd0);
    check_eq({tg, "_done_idx"}, 32'(triple(ch, row, col)), 32'd0);
    tick();
    check_idle({tg, "_after"});
  endtask

  initial begin
    #2;
    check_idle("reset_held");
    #10;
    reset = 1'b0;
    tick();
    check_idle("reset_rel");

    enable = 1'b1;
    tick();
    enable = 1'b0;
    check_idle("en_in_idle");

    scan(1'b0);
    scan(1'b1);

    do_start(5'd0, 5'd0, 8'd0);
    check_eq("degen_busy", 32'(busy), 32'd1);
    check_eq("degen_last", 32'(last), 32'd1);
    check_eq("degen_colwrap", 32'(col_wrap), 32'd1);
    check_eq("degen_rowwrap", 32'(row_wrap), 32'd1);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    check_eq("degen_done", 32'(done), 32'd1);
    tick();
    check_idle("degen_after");

    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    check_idle("clr_start");

    do_start(5'd2, 5'd1, 8'd1);
    start = 1'b1;
    enable = 1'b1;
    repeat (4) tick();
    enable = 1'b0;
    start = 1'b0;
    check_eq("mid_idx", 32'(triple(ch, row, col)), 32'(triple(8'd0, 5'd1, 5'd1)));
    clear = 1'b1;
    enable = 1'b1;
    tick();
    clear = 1'b0;
    enable = 1'b0;
    check_idle("mid_clear");

    do_start(5'd2, 5'd1, 8'd1);
    enable = 1'b1;
    repeat (3) tick();
    enable = 1'b0;
    check_eq("pre_rst_idx", 32'(triple(ch, row, col)), 32'(triple(8'd0, 5'd1, 5'd0)));
    #2;
    reset = 1'b1;
    #1;
    check_idle("async_rst");
    #4;
    reset = 1'b0;
    tick();
    check_idle("rst_resume");
    do_start(5'd0, 5'd0, 8'd0);
    check_eq("rst_restart_busy", 32'(busy), 32'd1);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    tick();

`ifdef CONV_CNT_STRIDE_EN
    col_stride = 5'd2;
    do_start(5'd4, 5'd1, 8'd0);
    col_stride = 5'd0;
    for (int i = 0; i < 6; i++) begin
      enable = 1'b1;
      check_eq("stride_col", 32'(col), 32'((i % 3) * 2));
      check_eq("stride_row", 32'(row), 32'(i / 3));
      check_eq("stride_colwrap", 32'(col_wrap), 32'((i % 3) == 2));
      check_eq("stride_last", 32'(last), 32'(i == 5));
      tick();
      enable = 1'b0;
    end
    check_eq("stride_done", 32'(done), 32'd1);
    tick();
    check_idle("stride_after");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_index_counter.md
CONV_INDEX_COUNTER -- requirements
Module: conv_index_counter

Interface
REQ-001 SHALL have parameter COL_W, default 5, column counter width in bits.
REQ-002 SHALL have parameter ROW_W, default 5, row counter width in bits.
REQ-003 SHALL have parameter CH_W, default 8, channel counter width in bits.
REQ-004 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1, launches one scan when IDLE.
REQ-007 SHALL have port enable, input, 1, advances the scan by one step when RUN.
REQ-008 SHALL have port clear, input, 1, synchronous abort to IDLE.
REQ-009 SHALL have ports col_max, row_max, ch_max, inputs, COL_W/ROW_W/CH_W, inclusive terminal values, sampled on accepted start.
REQ-010 SHALL have ports col, row, ch, outputs, COL_W/ROW_W/CH_W, current indices.
REQ-011 SHALL have ports col_wrap, row_wrap, outputs, 1, high while the respective index equals its latched max.
REQ-012 SHALL have ports busy, done, last, outputs, 1: busy in RUN; done a one-cycle end pulse; last high in RUN at the final index triple.

Function
REQ-013 SHALL implement FSM IDLE -> RUN on start; RUN -> DONE on enable while last; DONE -> IDLE unconditionally after one cycle.
REQ-014 SHALL, on accepted start, latch all three max values and set col=row=ch=0 in the same edge.
REQ-015 SHALL step nested: col increments; at col_max col->0 and row increments; at row_max row->0 and ch increments; at ch_max ch->0.
REQ-016 SHALL assert done only in DONE, exactly one cycle after the final enabled step; indices read 0 in DONE.
REQ-017 SHALL ignore enable in IDLE and DONE, and ignore start in RUN and DONE.
REQ-018 SHALL hold all indices when enable is low in RUN.
REQ-019 SHALL treat max=0 as a single-value dimension, wrapping on every step of that level; all max=0 yields last on the first RUN cycle.
REQ-020 SHALL give clear priority over start and enable: next state IDLE, indices 0, done low.
REQ-021 SHALL produce col_wrap, row_wrap and last from registered state only, with no combinational path from any input.
REQ-022 SHALL never exceed a latched max; max inputs changing in RUN have no effect.

Reset
REQ-023 SHALL, on reset asserted, immediately force IDLE, col=row=ch=0, latched max=0, busy=done=last=0, regardless of clock.
REQ-024 SHALL resume operation at the first rising edge after reset deasserts, starting in IDLE.

Configuration
REQ-025 SHALL, with CONV_CNT_STRIDE_EN defined, add input col_stride (COL_W, sampled on start) so col advances by the stride and wraps to 0 when col + stride > col_max; a latched stride of 0 is treated as 1.
REQ-026 SHALL, without CONV_CNT_STRIDE_EN, omit col_stride and use a fixed col step of 1.

Structure
REQ-027 SHALL place the FSM state enumeration and default width constants in shared package conv_cnt_pkg.
REQ-028 SHALL implement each dimension with one sub-module, wrap_counter (load-zero, step, max, wrap out), instantiated three times and chained by wrap.

Verification
REQ-029 SHALL cover the nested scan: col_max=2, row_max=1, ch_max=1, enable held high -> 12 RUN steps in order (0,0,0)...(2,1,1), then done for exactly 1 cycle, then busy=0.
REQ-030 SHALL cover stalls: the same scan with enable toggled every other cycle -> identical index sequence, done 1 cycle after the 12th enabled step.
REQ-031 SHALL cover degenerate dimensions: all max=0, start, then enable -> last=1 on the first RUN cycle and done on the next cycle.
REQ-032 SHALL cover priority: clear and start together in IDLE -> stays IDLE; clear mid-scan at (1,1,0) -> IDLE, indices 0 next cycle.
REQ-033 SHALL cover async reset mid-scan, asserted between edges -> outputs 0 and busy=0 before the next edge.
REQ-034 SHALL cover the stride option (CONV_CNT_STRIDE_EN): col_max=4, stride=2 -> col sequence 0,2,4,0, with row incrementing on each wrap.
